reg_port_arbiter: RTL and testbench

REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

---
 rtl/reg_port_arbiter_pkg.sv | 33 +++
 rtl/reg_port_arbiter_lock_timer.sv | 57 +++++
 rtl/reg_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_reg_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the register-port arbiter.
// Holds the register-bank geometry, the FSM state enum, the port identifiers
// and the latched-request struct used by the arbiter and its lock timer.
package reg_port_arbiter_pkg;

  localparam int unsigned REGCOUNT = 32;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I2C = 1'b0,
    PORT_IO  = 1'b1
  } port_e;

  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // True when the register index addresses an implemented register.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel,
                                        input int unsigned      num_regs);
    return 32'(sel) < num_regs;
  endfunction

endpackage

// File: rtl/reg_port_arbiter_lock_timer.sv
// Lock timer for the register-port arbiter.
// Counts cycles while the I2C side holds its lock, saturating at LOCK_TIMEOUT.
// When the count reaches LOCK_TIMEOUT a forced release is raised and held
// until the lock drops, so a stuck I2C transaction cannot starve the IO port.
//   clk, rst    : block clock, asynchronous active-high reset
//   lock_i      : I2C transaction in progress
//   inhibit_o   : IO grants must be held off this cycle
//   hit_o       : counter reaches LOCK_TIMEOUT at the coming edge
module reg_port_arbiter_lock_timer #(
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_i,
  output logic inhibit_o,
  output logic hit_o
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_q, force_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    force_d = force_q;
    hit_o   = 1'b0;
    if (!lock_i) begin
      cnt_d   = '0;
      force_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) begin
        hit_o   = 1'b1;
        force_d = 1'b1;
      end
    end
  end

  assign inhibit_o = lock_i && (cnt_q < CNT_MAX) && !force_q;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Arbiter sharing one register-bank port between an I2C slave and an IO bus.
// Each access runs IDLE -> ACCESS -> RESP: the winner's operands are latched
// when leaving IDLE, driven onto the bank during ACCESS, and the winner's
// completion pulse plus read data appear during RESP. Ties go to the port that
// was not granted last. While the I2C side holds its lock, IO requests wait
// until the lock drops or the lock timer forces a release.
//   clk, rst                          : block clock, async active-high reset
//   i2c_req/we/sel/wdata, i2c_lock    : I2C-side request and lock
//   i2c_gnt, i2c_rdata                : I2C completion pulse and read data
//   io_req/we/sel/wdata               : IO-side request
//   io_gnt, io_rdata                  : IO completion pulse and read data
//   mem_we/sel/wdata, mem_rdata       : register-bank port
//   lock_err_clr, lock_err, sel_err   : sticky error flags and their clear
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned NUM_REGS     = REGCOUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [SEL_W-1:0]  i2c_sel,
  input  logic [DATA_W-1:0] i2c_wdata,
  input  logic              i2c_lock,
  output logic              i2c_gnt,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [SEL_W-1:0]  io_sel,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic [DATA_W-1:0] io_rdata,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              lock_err_clr,
  output logic              lock_err,
  output logic              sel_err
);

  state_e            state_q;
  port_e             winner_q, last_q, pick;
  logic              sel_ok_q;
  logic              mem_we_q;
  logic [SEL_W-1:0]  mem_sel_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              i2c_gnt_q, io_gnt_q;
  logic [DATA_W-1:0] i2c_rdata_q, io_rdata_q;
  logic              lock_err_q, sel_err_q;

  logic lock_inhibit, timer_hit;
  logic i2c_elig, io_elig, any_elig, win_ok, sel_err_set;
  req_t i2c_op, io_op, win_op;

  reg_port_arbiter_lock_timer #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_timer (
    .clk       (clk),
    .rst       (rst),
    .lock_i    (i2c_lock),
    .inhibit_o (lock_inhibit),
    .hit_o     (timer_hit)
  );

  assign i2c_op   = {i2c_we, i2c_sel, i2c_wdata};
  assign io_op    = {io_we, io_sel, io_wdata};
  assign i2c_elig = i2c_req;
  assign io_elig  = io_req && !lock_inhibit;
  assign any_elig = i2c_elig || io_elig;

  // IO wins when it is the only eligible port, or on a tie when I2C was
  // granted last.
  assign pick   = (io_elig && (!i2c_elig || last_q == PORT_I2C)) ? PORT_IO : PORT_I2C;
  assign win_op = (pick == PORT_IO) ? io_op : i2c_op;
  assign win_ok = sel_in_range(win_op.sel, NUM_REGS);

  assign sel_err_set = (state_q == IDLE) && any_elig && !win_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      winner_q    <= PORT_I2C;
      last_q      <= PORT_IO;
      sel_ok_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      i2c_gnt_q   <= 1'b0;
      io_gnt_q    <= 1'b0;
      i2c_rdata_q <= '0;
      io_rdata_q  <= '0;
      lock_err_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      // Bank outputs and grants are only ever live for one state; clear them
      // every cycle and let the FSM raise them where they belong.
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_wdata_q <= '0;
      i2c_gnt_q   <= 1'b0;
      io_gnt_q    <= 1'b0;

      // A set in the same cycle as a clear wins.
      lock_err_q <= timer_hit || (lock_err_q && !lock_err_clr);
      sel_err_q  <= sel_err_set || (sel_err_q && !lock_err_clr);

      case (state_q)
        IDLE: begin
          if (any_elig) begin
            state_q     <= ACCESS;
            winner_q    <= pick;
            last_q      <= pick;
            sel_ok_q    <= win_ok;
            mem_we_q    <= win_op.we && win_ok;
            mem_sel_q   <= win_op.sel;
            mem_wdata_q <= win_op.wdata;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          // Read data is captured for writes too; out-of-range reads return 0.
          if (winner_q == PORT_IO) begin
            io_gnt_q   <= 1'b1;
            io_rdata_q <= sel_ok_q ? mem_rdata : '0;
          end else begin
            i2c_gnt_q   <= 1'b1;
            i2c_rdata_q <= sel_ok_q ? mem_rdata : '0;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i2c_gnt   = i2c_gnt_q;
  assign i2c_rdata = i2c_rdata_q;
  assign io_gnt    = io_gnt_q;
  assign io_rdata  = io_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_wdata = mem_wdata_q;
  assign lock_err  = lock_err_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter. A second instance with a 24-register
// bank shares every input with the main one: a 5-bit index cannot encode 32,
// so sel=31 on that instance exercises the out-of-range path while the main
// instance treats it as the last valid register.
module tb_reg_port_arbiter;
  import reg_port_arbiter_pkg::*;

  localparam int unsigned LT = 16;

  typedef struct {
    bit         is_io;
    logic [7:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic i2c_req, i2c_we, i2c_lock, io_req, io_we, lock_err_clr;
  logic [4:0] i2c_sel, io_sel;
  logic [7:0] i2c_wdata, io_wdata;
  logic [7:0] mem_rdata;

  logic       i2c_gnt, io_gnt, mem_we, lock_err, sel_err;
  logic [7:0] i2c_rdata, io_rdata, mem_wdata;
  logic [4:0] mem_sel;

  logic       s_i2c_gnt, s_io_gnt, s_mem_we, s_lock_err, s_sel_err;
  logic [7:0] s_i2c_rdata, s_io_rdata, s_mem_wdata;
  logic [4:0] s_mem_sel;

  logic [7:0] mem [32];
  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  reg_port_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_sel(i2c_sel), .i2c_wdata(i2c_wdata),
    .i2c_lock(i2c_lock), .i2c_gnt(i2c_gnt), .i2c_rdata(i2c_rdata),
    .io_req(io_req), .io_we(io_we), .io_sel(io_sel), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rdata(io_rdata),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_err_clr(lock_err_clr), .lock_err(lock_err), .sel_err(sel_err)
  );

  reg_port_arbiter #(.LOCK_TIMEOUT(LT), .NUM_REGS(24)) dut_small (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_sel(i2c_sel), .i2c_wdata(i2c_wdata),
    .i2c_lock(i2c_lock), .i2c_gnt(s_i2c_gnt), .i2c_rdata(s_i2c_rdata),
    .io_req(io_req), .io_we(io_we), .io_sel(io_sel), .io_wdata(io_wdata),
    .io_gnt(s_io_gnt), .io_rdata(s_io_rdata),
    .mem_we(s_mem_we), .mem_sel(s_mem_sel), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .lock_err_clr(lock_err_clr), .lock_err(s_lock_err), .sel_err(s_sel_err)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 7 + 17);
  endfunction

  // Register bank model: combinational read, write on the clock edge,
  // reloaded with known contents while reset is held.
  assign mem_rdata = mem[mem_sel];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_sel] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next completion, then checks it against the
  // oldest scoreboard entry: which port, its read data and the latency in
  // falling edges since the call.
  task automatic wait_gnt(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i2c_gnt && !io_gnt && n < 12);
    e.is_io = 1'b0;
    e.rdata = 8'h00;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_who"}, {30'd0, i2c_gnt, io_gnt}, e.is_io ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, e.is_io ? {24'd0, io_rdata} : {24'd0, i2c_rdata}, {24'd0, e.rdata});
    check({tag, "_lat"}, n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  early;

    rst = 1'b1;
    i2c_req = 0; i2c_we = 0; i2c_sel = '0; i2c_wdata = '0; i2c_lock = 0;
    io_req = 0; io_we = 0; io_sel = '0; io_wdata = '0; lock_err_clr = 0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_gnts", {i2c_gnt, io_gnt}, 0);
    check("rst_rdata", {i2c_rdata, io_rdata}, 0);
    check("rst_mem", {mem_we, mem_sel, mem_wdata}, 0);
    check("rst_errs", {lock_err, sel_err}, 0);
    rst = 1'b0;

    // IO write sel=3 data=A5: bank write during ACCESS, io_gnt two cycles on
    io_req = 1; io_we = 1; io_sel = 5'd3; io_wdata = 8'hA5;
    sb.push_back('{is_io: 1'b1, rdata: init_val(3)});
    @(negedge clk);
    check("wr3_mem_we", mem_we, 1);
    check("wr3_mem_sel", mem_sel, 3);
    check("wr3_mem_wdata", mem_wdata, 8'hA5);
    check("wr3_no_gnt_yet", io_gnt, 0);
    wait_gnt("wr3", 1);
    check("wr3_mem_we_off", mem_we, 0);
    io_req = 0; io_we = 0;
    @(negedge clk);

    // I2C read back of sel=3; IO read data must hold
    i2c_req = 1; i2c_we = 0; i2c_sel = 5'd3;
    sb.push_back('{is_io: 1'b0, rdata: 8'hA5});
    wait_gnt("rd3", 2);
    check("io_rdata_hold", io_rdata, init_val(3));
    i2c_req = 0;
    @(negedge clk);

    // Both ports requesting continuously after reset: I2C, IO, I2C, IO
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i2c_req = 1; i2c_sel = 5'd5;
    io_req = 1; io_we = 0; io_sel = 5'd7;
    sb.push_back('{is_io: 1'b0, rdata: init_val(5)});
    sb.push_back('{is_io: 1'b1, rdata: init_val(7)});
    sb.push_back('{is_io: 1'b0, rdata: init_val(5)});
    sb.push_back('{is_io: 1'b1, rdata: init_val(7)});
    wait_gnt("rr0", 2);
    wait_gnt("rr1", 3);
    wait_gnt("rr2", 3);
    wait_gnt("rr3", 3);
    i2c_req = 0; io_req = 0;
    @(negedge clk);

    // sel=31: last valid register on the main instance, out of range on the
    // small one. The clear is sampled on the same edge sel_err sets.
    io_req = 1; io_we = 1; io_sel = 5'd31; io_wdata = 8'h5C; lock_err_clr = 1;
    sb.push_back('{is_io: 1'b1, rdata: init_val(31)});
    @(negedge clk);
    lock_err_clr = 0;
    check("wr31_mem_we", mem_we, 1);
    check("wr31_small_no_we", s_mem_we, 0);
    wait_gnt("wr31", 1);
    check("wr31_small_gnt", s_io_gnt, 1);
    check("wr31_small_rdata", s_io_rdata, 0);
    check("wr31_small_sel_err", s_sel_err, 1);
    check("wr31_main_sel_err", sel_err, 0);
    io_req = 0; io_we = 0;
    @(negedge clk);

    i2c_req = 1; i2c_we = 0; i2c_sel = 5'd31;
    sb.push_back('{is_io: 1'b0, rdata: 8'h5C});
    wait_gnt("rd31", 2);
    check("rd31_small_gnt", s_i2c_gnt, 1);
    check("rd31_small_rdata", s_i2c_rdata, 0);
    i2c_req = 0;
    @(negedge clk);
    lock_err_clr = 1;
    @(negedge clk);
    lock_err_clr = 0;
    check("sel_err_cleared", s_sel_err, 0);

    // Lock held with IO waiting: no grant until the timer forces release
    i2c_lock = 1; io_req = 1; io_we = 0; io_sel = 5'd9;
    sb.push_back('{is_io: 1'b1, rdata: init_val(9)});
    n = 0;
    early = 0;
    do begin
      @(negedge clk);
      n++;
      if (io_gnt) early = 1;
    end while (!lock_err && n < LT + 8);
    check("lock_wait", n, LT);
    check("lock_early_gnt", early, 0);
    wait_gnt("lock_rel", 2);
    io_req = 0; i2c_lock = 0;
    @(negedge clk);
    check("lock_err_sticky", lock_err, 1);
    lock_err_clr = 1;
    @(negedge clk);
    lock_err_clr = 0;
    check("lock_err_cleared", lock_err, 0);

    // Reset in ACCESS: outputs drop immediately, the access yields no grant
    i2c_req = 1; i2c_we = 0; i2c_sel = 5'd4;
    @(negedge clk);
    check("abort_mem_sel", mem_sel, 4);
    #2 rst = 1'b1;
    #1;
    check("abort_rdata", {i2c_rdata, io_rdata}, 0);
    check("abort_mem", {mem_we, mem_sel, mem_wdata}, 0);
    check("abort_gnts", {i2c_gnt, io_gnt}, 0);
    i2c_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_gnt", {i2c_gnt, io_gnt, mem_we}, 0);
    end
    rst = 1'b0;
    i2c_req = 1; i2c_sel = 5'd4;
    sb.push_back('{is_io: 1'b0, rdata: init_val(4)});
    wait_gnt("after_rst", 2);
    i2c_req = 0;
    @(negedge clk);
    check("after_rst_gnt_off", {i2c_gnt, io_gnt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
